// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives the next PC and the instruction-memory request handshake.
// Optional exception entry/return support is compiled in when FETCH_EXC_EN is defined.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_4180
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] pc_next,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        exc_req,
  input  logic        eret,
  output logic [31:0] epc
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t      state, state_d;
  logic        pend_valid, pend_valid_d;
  logic [31:0] pend_tgt, pend_tgt_d;

  // Control transfer requested this cycle, already resolved by priority.
  logic        xfer;
  logic [31:0] xfer_tgt;

`ifdef FETCH_EXC_EN
  logic [31:0] epc_q;

  always_comb begin
    xfer     = redirect;
    xfer_tgt = {redirect_target[31:2], 2'b00};
    if (exc_req) begin
      xfer     = 1'b1;
      xfer_tgt = EXC_VECTOR;
    end else if (eret) begin
      xfer     = 1'b1;
      xfer_tgt = epc_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      epc_q <= '0;
    end else if (exc_req && state != BOOT) begin
      epc_q <= pc;
    end
  end

  assign epc = epc_q;
`else
  logic unused_exc;

  always_comb begin
    xfer     = redirect;
    xfer_tgt = {redirect_target[31:2], 2'b00};
  end

  assign unused_exc = ^{exc_req, eret, EXC_VECTOR, redirect_target[1:0]};
  assign epc        = '0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= BOOT;
      pend_valid <= 1'b0;
      pend_tgt   <= '0;
    end else begin
      state      <= state_d;
      pend_valid <= pend_valid_d;
      pend_tgt   <= pend_tgt_d;
    end
  end

  always_comb begin
    state_d      = state;
    pend_valid_d = pend_valid;
    pend_tgt_d   = pend_tgt;
    pc_next      = pc;
    imem_req     = 1'b0;
    instr_valid  = 1'b0;
    case (state)
      BOOT: begin
        pc_next = RESET_VECTOR;
        state_d = FETCH;
      end
      FETCH, WAIT: begin
        imem_req = 1'b1;
        if (!imem_ack) begin
          // Request still outstanding: park any transfer until the word returns.
          state_d = WAIT;
          if (xfer) begin
            pend_valid_d = 1'b1;
            pend_tgt_d   = xfer_tgt;
          end
        end else if (xfer) begin
          pc_next      = xfer_tgt;
          pend_valid_d = 1'b0;
          state_d      = FETCH;
        end else if (pend_valid) begin
          pc_next      = pend_tgt;
          pend_valid_d = 1'b0;
          state_d      = FETCH;
        end else if (stall) begin
          instr_valid = 1'b1;
          state_d     = HOLD;
        end else begin
          instr_valid = 1'b1;
          pc_next     = pc + 32'd4;
          state_d     = FETCH;
        end
      end
      HOLD: begin
        if (xfer) begin
          pc_next = xfer_tgt;
          state_d = FETCH;
        end else begin
          instr_valid = 1'b1;
          if (!stall) begin
            pc_next = pc + 32'd4;
            state_d = FETCH;
          end
        end
      end
      default: state_d = BOOT;
    endcase
  end

endmodule
